// File: rtl/spi_regs_pkg.sv
// spi_regs_pkg: shared state encoding, command bit positions and default dummy byte
package spi_regs_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WR, RD, ERR} state_t;
  localparam int RW_BIT = 7;
  localparam logic [7:0] DUMMY_BYTE_DEF = 8'h00;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser with registered edge detect producing rise/fall pulses
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= {3{RST_VAL}};
    else {s1, s2, s3} <= {d, s1, s2};
  assign q = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI byte command decoder and register bank with auto-incrementing bursts.
// Optional SPI_SLAVE_REGS_STATUS_EN makes the top address a read-only rejected-command counter.
module spi_slave_regs
  import spi_regs_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter logic [7:0] DUMMY_BYTE = DUMMY_BYTE_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      cs,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [7:0]                tx_data,
  output logic [8*(2**ADDR_W)-1:0]  reg_flat,
  output logic                      wr_pulse,
  output logic [ADDR_W-1:0]         wr_addr
);
  localparam int N = 2**ADDR_W;
  state_t state, state_n;
  logic [N-1:0][7:0] regs;
  logic [ADDR_W-1:0] ptr, ptr_inc, cmd_addr;
  logic cs_q, cs_rise, cs_fall, rx_ok, cmd_bad, wr_ok;
  logic [7:0] rd_cmd, rd_next;
  // Synchroniser resets low so a cs already low at reset release gives no frame start
  sync_edge #(.RST_VAL(1'b0)) u_cs (
    .clk(sys_clk), .rst(sys_rst), .d(cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  assign rx_ok = rx_valid & ~cs_q & ~cs_fall;
  assign cmd_bad = (rx_data[6:0] >> ADDR_W) != 7'd0;
  assign cmd_addr = rx_data[ADDR_W-1:0];
  assign ptr_inc = ptr + 1'b1;
  assign reg_flat = regs;
`ifdef SPI_SLAVE_REGS_STATUS_EN
  localparam logic [ADDR_W-1:0] TOP = '1;
  logic [7:0] err_cnt;
  assign rd_cmd = (cmd_addr == TOP) ? err_cnt : regs[cmd_addr];
  assign rd_next = (ptr_inc == TOP) ? err_cnt : regs[ptr_inc];
  assign wr_ok = ptr != TOP;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) err_cnt <= 8'd0;
    else if (!cs_rise && rx_ok && state == CMD && cmd_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`else
  assign rd_cmd = regs[cmd_addr];
  assign rd_next = regs[ptr_inc];
  assign wr_ok = 1'b1;
`endif
  always_comb begin
    state_n = state;
    if (cs_rise) state_n = IDLE;
    else if (cs_fall) state_n = CMD;
    else if (rx_ok && state == CMD) state_n = cmd_bad ? ERR : rx_data[RW_BIT] ? RD : WR;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      regs <= '0;
      ptr <= '0;
      tx_data <= DUMMY_BYTE;
      wr_pulse <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (cs_rise || cs_fall) tx_data <= DUMMY_BYTE;
      else if (rx_ok && state == CMD) begin
        ptr <= cmd_addr;
        tx_data <= (!cmd_bad && rx_data[RW_BIT]) ? rd_cmd : DUMMY_BYTE;
      end else if (rx_ok && state == WR) begin
        ptr <= ptr_inc;
        if (wr_ok) begin
          regs[ptr] <= rx_data;
          wr_pulse <= 1'b1;
          wr_addr <= ptr;
        end
      end else if (rx_ok && state == RD) begin
        ptr <= ptr_inc;
        tx_data <= rd_next;
      end
    end
endmodule
